// File: rtl/runahead_pkg.sv
`default_nettype none
// ============================================================================
// Module   : runahead_pkg
// Purpose  : Shared widths, queue entry layout and register one-hot helper
//            for the runahead issue queue.
// Revision : 1.0 - initial release
// ============================================================================
package runahead_pkg;

  localparam int REG_COUNT  = 16;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);
  localparam int PAYLOAD_W  = 16;

  // One queue slot; wait_* mean "operand still owed by a multicycle writer"
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] a_addr;
    logic [REG_ADDR_W-1:0] b_addr;
    logic                  b_used;
    logic                  writes_a;
    logic                  multicycle;
    logic [PAYLOAD_W-1:0]  payload;
    logic                  wait_a;
    logic                  wait_b;
  } runahead_entry_t;

  function automatic logic [REG_COUNT-1:0] onehot_reg(input logic [REG_ADDR_W-1:0] addr);
    logic [REG_COUNT-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/runahead_queue_entry.sv
`default_nettype none
// ============================================================================
// Module   : runahead_queue_entry
// Purpose  : Single queue slot. Captures a pushed instruction and retires its
//            operand waits as the matching load completions arrive.
// Revision : 1.0 - initial release
// ============================================================================
module runahead_queue_entry
  import runahead_pkg::*;
(
  input  logic                 clk,
  input  logic                 async_rst,
  input  logic                 clk_en_i,
  input  logic [REG_COUNT-1:0] load_valid_i,
  input  logic                 wr_en_i,
  input  runahead_entry_t      wr_data_i,
  input  logic                 clr_i,
  output runahead_entry_t      entry_o
);

  runahead_entry_t entry_q;

  // Capture on push, free on issue, and drop waits when the owed load lands
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      entry_q <= '0;
    end else if (clk_en_i) begin
      if (wr_en_i) begin
        entry_q <= wr_data_i;
      end else begin
        if (clr_i) entry_q.valid <= 1'b0;
        if (load_valid_i[entry_q.a_addr]) entry_q.wait_a <= 1'b0;
        if (load_valid_i[entry_q.b_addr]) entry_q.wait_b <= 1'b0;
      end
    end
  end

  assign entry_o = entry_q;

endmodule
`default_nettype wire

// File: rtl/runahead_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : runahead_issue_queue
// Purpose  : In-order runahead queue in front of execute. Drives scoreboard
//            push marks, holds instructions until pending load writes to
//            their operands complete, and issues oldest-first.
// Revision : 1.0 - initial release
// ============================================================================
module runahead_issue_queue
  import runahead_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  clk_en,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [REG_ADDR_W-1:0] push_a_addr,
  input  logic [REG_ADDR_W-1:0] push_b_addr,
  input  logic                  push_b_used,
  input  logic                  push_writes_a,
  input  logic                  push_multicycle,
  input  logic [PAYLOAD_W-1:0]  push_payload,
  input  logic [REG_COUNT-1:0]  reg_dirty,
  input  logic [REG_COUNT-1:0]  load_valid,
  output logic [REG_COUNT-1:0]  used_as_a,
  output logic [REG_COUNT-1:0]  used_as_b,
  output logic                  will_be_writing_a,
  output logic                  mark_dirty,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [PAYLOAD_W-1:0]  issue_payload,
  output logic [REG_COUNT-1:0]  issued_as_a,
  output logic [REG_COUNT-1:0]  issued_as_b
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(QUEUE_DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  runahead_entry_t w_entries [QUEUE_DEPTH];
  runahead_entry_t w_head;
  runahead_entry_t w_push_entry;
  logic            w_mc_conflict;
  logic            w_push_fire;
  logic            w_issue_fire;
  logic            w_unused_head;

  assign w_head = w_entries[rd_ptr_q];

  // A second multicycle writer to a still-dirty register is held off at push
  assign w_mc_conflict = push_multicycle && push_writes_a && reg_dirty[push_a_addr];
  assign push_ready    = clk_en && !async_rst && (count_q != C_DEPTH) && !w_mc_conflict;
  assign w_push_fire   = push_valid && push_ready;

  assign issue_valid   = clk_en && w_head.valid && !w_head.wait_a && !w_head.wait_b;
  assign w_issue_fire  = issue_valid && issue_ready;
  assign issue_payload = w_head.payload;

  // Only operand addresses and payload leave through the issue port
  assign w_unused_head = ^{w_head.writes_a, w_head.multicycle};

  // Build the captured entry, folding a same-cycle load completion into the waits
  always_comb begin
    w_push_entry            = '0;
    w_push_entry.valid      = 1'b1;
    w_push_entry.a_addr     = push_a_addr;
    w_push_entry.b_addr     = push_b_addr;
    w_push_entry.b_used     = push_b_used;
    w_push_entry.writes_a   = push_writes_a;
    w_push_entry.multicycle = push_multicycle;
    w_push_entry.payload    = push_payload;
    w_push_entry.wait_a     = reg_dirty[push_a_addr] && !load_valid[push_a_addr];
    w_push_entry.wait_b     = push_b_used && reg_dirty[push_b_addr] && !load_valid[push_b_addr];
  end

  // Push-side scoreboard marks, live only in the accepting cycle
  always_comb begin
    used_as_a         = '0;
    used_as_b         = '0;
    will_be_writing_a = 1'b0;
    mark_dirty        = 1'b0;
    if (w_push_fire) begin
      used_as_a         = onehot_reg(push_a_addr);
      used_as_b         = push_b_used ? onehot_reg(push_b_addr) : '0;
      will_be_writing_a = push_writes_a;
      mark_dirty        = push_multicycle && push_writes_a;
    end
  end

  // Issue-side strobes, live only in the issuing cycle
  always_comb begin
    issued_as_a = '0;
    issued_as_b = '0;
    if (w_issue_fire) begin
      issued_as_a = onehot_reg(w_head.a_addr);
      issued_as_b = w_head.b_used ? onehot_reg(w_head.b_addr) : '0;
    end
  end

  generate
    for (genvar i = 0; i < QUEUE_DEPTH; i++) begin : g_entry
      runahead_queue_entry u_entry (
        .clk          (clk),
        .async_rst    (async_rst),
        .clk_en_i     (clk_en),
        .load_valid_i (load_valid),
        .wr_en_i      (w_push_fire && (wr_ptr_q == PTR_W'(i))),
        .wr_data_i    (w_push_entry),
        .clr_i        (w_issue_fire && (rd_ptr_q == PTR_W'(i))),
        .entry_o      (w_entries[i])
      );
    end
  endgenerate

  // Next pointers and occupancy; simultaneous push and issue cancel in count
  always_comb begin
    wr_ptr_d = wr_push_next();
    rd_ptr_d = w_issue_fire ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({w_push_fire, w_issue_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  function automatic logic [PTR_W-1:0] wr_push_next();
    return w_push_fire ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  endfunction

  // Pointer and count state, frozen while clk_en is low
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clk_en) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_runahead_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_runahead_issue_queue
// Purpose  : Directed self-checking bench for runahead_issue_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_runahead_issue_queue;
  import runahead_pkg::*;

  logic                  clk = 1'b0;
  logic                  async_rst;
  logic                  clk_en;
  logic                  push_valid;
  logic                  push_ready;
  logic [REG_ADDR_W-1:0] push_a_addr;
  logic [REG_ADDR_W-1:0] push_b_addr;
  logic                  push_b_used;
  logic                  push_writes_a;
  logic                  push_multicycle;
  logic [PAYLOAD_W-1:0]  push_payload;
  logic [REG_COUNT-1:0]  reg_dirty;
  logic [REG_COUNT-1:0]  load_valid;
  logic [REG_COUNT-1:0]  used_as_a;
  logic [REG_COUNT-1:0]  used_as_b;
  logic                  will_be_writing_a;
  logic                  mark_dirty;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [PAYLOAD_W-1:0]  issue_payload;
  logic [REG_COUNT-1:0]  issued_as_a;
  logic [REG_COUNT-1:0]  issued_as_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  runahead_issue_queue #(.QUEUE_DEPTH(4)) dut (
    .clk               (clk),
    .async_rst         (async_rst),
    .clk_en            (clk_en),
    .push_valid        (push_valid),
    .push_ready        (push_ready),
    .push_a_addr       (push_a_addr),
    .push_b_addr       (push_b_addr),
    .push_b_used       (push_b_used),
    .push_writes_a     (push_writes_a),
    .push_multicycle   (push_multicycle),
    .push_payload      (push_payload),
    .reg_dirty         (reg_dirty),
    .load_valid        (load_valid),
    .used_as_a         (used_as_a),
    .used_as_b         (used_as_b),
    .will_be_writing_a (will_be_writing_a),
    .mark_dirty        (mark_dirty),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_payload     (issue_payload),
    .issued_as_a       (issued_as_a),
    .issued_as_b       (issued_as_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    push_valid      = 1'b0;
    push_a_addr     = '0;
    push_b_addr     = '0;
    push_b_used     = 1'b0;
    push_writes_a   = 1'b0;
    push_multicycle = 1'b0;
    push_payload    = '0;
    reg_dirty       = '0;
    load_valid      = '0;
    issue_ready     = 1'b0;
  endtask

  task automatic drive_push(input logic [3:0] a, input logic [3:0] b, input logic bu,
                            input logic wa, input logic mc, input logic [15:0] pl);
    push_valid      = 1'b1;
    push_a_addr     = a;
    push_b_addr     = b;
    push_b_used     = bu;
    push_writes_a   = wa;
    push_multicycle = mc;
    push_payload    = pl;
  endtask

  task automatic test_reset;
    async_rst = 1'b1;
    clk_en    = 1'b1;
    idle();
    push_valid = 1'b1;
    #2;
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL rst_push_ready got=%0h exp=0", push_ready); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rst_issue_valid got=%0h exp=0", issue_valid); end
    total++; if (used_as_a !== 16'h0000) begin bad++; $display("FAIL rst_used_as_a got=%0h exp=0", used_as_a); end
    tick();
    async_rst  = 1'b0;
    push_valid = 1'b0;
    #1;
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL rel_push_ready got=%0h exp=1", push_ready); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rel_issue_valid got=%0h exp=0", issue_valid); end
    total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL rel_count got=%0d exp=0", dut.count_q); end
  endtask

  task automatic test_basic;
    tick();
    drive_push(4'd3, 4'd5, 1'b1, 1'b1, 1'b0, 16'hA001);
    #1;
    total++; if (used_as_a !== 16'h0008) begin bad++; $display("FAIL basic_used_a got=%0h exp=0008", used_as_a); end
    total++; if (used_as_b !== 16'h0020) begin bad++; $display("FAIL basic_used_b got=%0h exp=0020", used_as_b); end
    total++; if (will_be_writing_a !== 1'b1) begin bad++; $display("FAIL basic_will_write got=%0h exp=1", will_be_writing_a); end
    total++; if (mark_dirty !== 1'b0) begin bad++; $display("FAIL basic_mark_dirty got=%0h exp=0", mark_dirty); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL basic_no_bypass got=%0h exp=0", issue_valid); end
    tick();
    push_valid  = 1'b0;
    issue_ready = 1'b1;
    #1;
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL basic_issue_valid got=%0h exp=1", issue_valid); end
    total++; if (issued_as_a !== 16'h0008) begin bad++; $display("FAIL basic_issued_a got=%0h exp=0008", issued_as_a); end
    total++; if (issued_as_b !== 16'h0020) begin bad++; $display("FAIL basic_issued_b got=%0h exp=0020", issued_as_b); end
    total++; if (issue_payload !== 16'hA001) begin bad++; $display("FAIL basic_payload got=%0h exp=a001", issue_payload); end
    total++; if (used_as_a !== 16'h0000) begin bad++; $display("FAIL basic_used_idle got=%0h exp=0", used_as_a); end
    tick();
    issue_ready = 1'b0;
    #1;
    total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL basic_count got=%0d exp=0", dut.count_q); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%0h exp=0", issue_valid); end
  endtask

  task automatic test_load_wait;
    drive_push(4'd2, 4'd0, 1'b0, 1'b1, 1'b1, 16'hB002);
    #1;
    total++; if (mark_dirty !== 1'b1) begin bad++; $display("FAIL load_mark_dirty got=%0h exp=1", mark_dirty); end
    total++; if (used_as_a !== 16'h0004) begin bad++; $display("FAIL load_used_a got=%0h exp=0004", used_as_a); end
    total++; if (used_as_b !== 16'h0000) begin bad++; $display("FAIL load_used_b got=%0h exp=0", used_as_b); end
    tick();
    push_valid  = 1'b0;
    issue_ready = 1'b1;
    #1;
    total++; if (issued_as_a !== 16'h0004) begin bad++; $display("FAIL load_issued_a got=%0h exp=0004", issued_as_a); end
    total++; if (issued_as_b !== 16'h0000) begin bad++; $display("FAIL load_issued_b got=%0h exp=0", issued_as_b); end
    tick();
    issue_ready = 1'b0;
    reg_dirty   = 16'h0004;
    drive_push(4'd9, 4'd2, 1'b1, 1'b0, 1'b0, 16'hB003);
    #1;
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL reader_push_ready got=%0h exp=1", push_ready); end
    tick();
    push_valid = 1'b0;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reader_wait1 got=%0h exp=0", issue_valid); end
    tick();
    load_valid = 16'h0004;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reader_wait_lv got=%0h exp=0", issue_valid); end
    tick();
    load_valid  = '0;
    reg_dirty   = '0;
    issue_ready = 1'b1;
    #1;
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL reader_release got=%0h exp=1", issue_valid); end
    total++; if (issued_as_b !== 16'h0004) begin bad++; $display("FAIL reader_issued_b got=%0h exp=0004", issued_as_b); end
    total++; if (issue_payload !== 16'hB003) begin bad++; $display("FAIL reader_payload got=%0h exp=b003", issue_payload); end
    tick();
    issue_ready = 1'b0;
    // load completion coinciding with the push is folded in at capture
    reg_dirty  = 16'h0004;
    load_valid = 16'h0004;
    drive_push(4'd9, 4'd2, 1'b1, 1'b0, 1'b0, 16'hB004);
    tick();
    push_valid  = 1'b0;
    load_valid  = '0;
    reg_dirty   = '0;
    issue_ready = 1'b1;
    #1;
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL fold_issue_valid got=%0h exp=1", issue_valid); end
    total++; if (issue_payload !== 16'hB004) begin bad++; $display("FAIL fold_payload got=%0h exp=b004", issue_payload); end
    tick();
    issue_ready = 1'b0;
  endtask

  task automatic test_mc_block;
    reg_dirty = 16'h0080;
    drive_push(4'd7, 4'd0, 1'b0, 1'b1, 1'b1, 16'hC001);
    #1;
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL mc_block_ready got=%0h exp=0", push_ready); end
    total++; if (used_as_a !== 16'h0000) begin bad++; $display("FAIL mc_block_used got=%0h exp=0", used_as_a); end
    total++; if (mark_dirty !== 1'b0) begin bad++; $display("FAIL mc_block_dirty got=%0h exp=0", mark_dirty); end
    tick();
    #1;
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL mc_block_ready2 got=%0h exp=0", push_ready); end
    total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL mc_block_count got=%0d exp=0", dut.count_q); end
    tick();
    reg_dirty = '0;
    #1;
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL mc_free_ready got=%0h exp=1", push_ready); end
    total++; if (mark_dirty !== 1'b1) begin bad++; $display("FAIL mc_free_dirty got=%0h exp=1", mark_dirty); end
    tick();
    push_valid  = 1'b0;
    issue_ready = 1'b1;
    #1;
    total++; if (issue_payload !== 16'hC001 || issue_valid !== 1'b1) begin bad++; $display("FAIL mc_issue got=%0h/%0h exp=c001/1", issue_payload, issue_valid); end
    tick();
    issue_ready = 1'b0;
  endtask

  task automatic test_clk_en;
    drive_push(4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 16'hE001);
    tick();
    clk_en = 1'b0;
    drive_push(4'd2, 4'd0, 1'b0, 1'b1, 1'b0, 16'hE002);
    issue_ready = 1'b1;
    #1;
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL cen_push_ready got=%0h exp=0", push_ready); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL cen_issue_valid got=%0h exp=0", issue_valid); end
    total++; if (used_as_a !== 16'h0000 || issued_as_a !== 16'h0000) begin bad++; $display("FAIL cen_strobes got=%0h/%0h exp=0/0", used_as_a, issued_as_a); end
    tick();
    #1;
    total++; if (dut.count_q !== 3'd1) begin bad++; $display("FAIL cen_count got=%0d exp=1", dut.count_q); end
    clk_en     = 1'b1;
    push_valid = 1'b0;
    #1;
    total++; if (issue_valid !== 1'b1 || issue_payload !== 16'hE001) begin bad++; $display("FAIL cen_resume got=%0h/%0h exp=1/e001", issue_valid, issue_payload); end
    tick();
    issue_ready = 1'b0;
  endtask

  task automatic test_blocked_head;
    issue_ready = 1'b1;
    reg_dirty   = 16'h0010;
    drive_push(4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 16'hD001);
    tick();
    drive_push(4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 16'hD002);
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL blk_head_wait got=%0h exp=0", issue_valid); end
    tick();
    drive_push(4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 16'hD003);
    tick();
    push_valid = 1'b0;
    #1;
    total++; if (issue_valid !== 1'b0 || issued_as_a !== 16'h0000) begin bad++; $display("FAIL blk_younger got=%0h/%0h exp=0/0", issue_valid, issued_as_a); end
    total++; if (dut.count_q !== 3'd3) begin bad++; $display("FAIL blk_count got=%0d exp=3", dut.count_q); end
    tick();
    load_valid = 16'h0010;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL blk_lv_cycle got=%0h exp=0", issue_valid); end
    tick();
    load_valid = '0;
    reg_dirty  = '0;
    #1;
    total++; if (issued_as_a !== 16'h0010 || issue_payload !== 16'hD001) begin bad++; $display("FAIL blk_head got=%0h/%0h exp=0010/d001", issued_as_a, issue_payload); end
    tick();
    total++; if (issued_as_a !== 16'h0002 || issue_payload !== 16'hD002) begin bad++; $display("FAIL blk_second got=%0h/%0h exp=0002/d002", issued_as_a, issue_payload); end
    tick();
    total++; if (issued_as_a !== 16'h0040 || issue_payload !== 16'hD003) begin bad++; $display("FAIL blk_third got=%0h/%0h exp=0040/d003", issued_as_a, issue_payload); end
    tick();
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL blk_drained got=%0h exp=0", issue_valid); end
    issue_ready = 1'b0;
  endtask

  task automatic test_full_wrap;
    async_rst = 1'b1;
    #1;
    async_rst = 1'b0;
    #1;
    for (int k = 1; k <= 4; k++) begin
      drive_push(4'(k), 4'd0, 1'b0, 1'b0, 1'b0, 16'(k));
      #1;
      total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%0h exp=1", k, push_ready); end
      tick();
    end
    drive_push(4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 16'd5);
    #1;
    total++; if (dut.count_q !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", dut.count_q); end
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0h exp=0", push_ready); end
    total++; if (dut.wr_ptr_q !== 2'd0) begin bad++; $display("FAIL full_wr_ptr got=%0d exp=0", dut.wr_ptr_q); end
    issue_ready = 1'b1;
    #1;
    total++; if (issue_valid !== 1'b1 || issue_payload !== 16'd1) begin bad++; $display("FAIL full_issue got=%0h/%0h exp=1/1", issue_valid, issue_payload); end
    total++; if (used_as_a !== 16'h0000 || push_ready !== 1'b0) begin bad++; $display("FAIL full_refused got=%0h/%0h exp=0/0", used_as_a, push_ready); end
    tick();
    total++; if (dut.count_q !== 3'd3) begin bad++; $display("FAIL after_full_count got=%0d exp=3", dut.count_q); end
    total++; if (push_ready !== 1'b1 || issue_payload !== 16'd2) begin bad++; $display("FAIL simul1 got=%0h/%0h exp=1/2", push_ready, issue_payload); end
    tick();
    drive_push(4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 16'd6);
    #1;
    total++; if (dut.count_q !== 3'd3 || issue_payload !== 16'd3) begin bad++; $display("FAIL simul2 got=%0d/%0h exp=3/3", dut.count_q, issue_payload); end
    total++; if (dut.wr_ptr_q !== 2'd1) begin bad++; $display("FAIL wrap_wr_ptr got=%0d exp=1", dut.wr_ptr_q); end
    tick();
    push_valid = 1'b0;
    for (int e = 4; e <= 6; e++) begin
      total++; if (issue_valid !== 1'b1 || issue_payload !== 16'(e)) begin bad++; $display("FAIL order_%0d got=%0h/%0h exp=1/%0h", e, issue_valid, issue_payload, e); end
      tick();
    end
    total++; if (dut.count_q !== 3'd0 || issue_valid !== 1'b0) begin bad++; $display("FAIL wrap_drained got=%0d/%0h exp=0/0", dut.count_q, issue_valid); end
    issue_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    issue_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive_push(4'(k), 4'd0, 1'b0, 1'b0, 1'b0, 16'hF000 + 16'(k));
      tick();
    end
    drive_push(4'd8, 4'd9, 1'b1, 1'b1, 1'b1, 16'hF004);
    #1;
    total++; if (push_ready !== 1'b1 || mark_dirty !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0h/%0h exp=1/1", push_ready, mark_dirty); end
    async_rst = 1'b1;
    #1;
    total++; if (push_ready !== 1'b0 || mark_dirty !== 1'b0 || used_as_b !== 16'h0000) begin bad++; $display("FAIL mid_rst_push got=%0h/%0h/%0h exp=0/0/0", push_ready, mark_dirty, used_as_b); end
    total++; if (issue_valid !== 1'b0 || dut.count_q !== 3'd0) begin bad++; $display("FAIL mid_rst_state got=%0h/%0d exp=0/0", issue_valid, dut.count_q); end
    tick();
    tick();
    async_rst  = 1'b0;
    push_valid = 1'b0;
    #1;
    total++; if (push_ready !== 1'b1 || issue_valid !== 1'b0 || dut.count_q !== 3'd0) begin bad++; $display("FAIL mid_release got=%0h/%0h/%0d exp=1/0/0", push_ready, issue_valid, dut.count_q); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_wait();
    test_mc_block();
    test_clk_en();
    test_blocked_head();
    test_full_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
